// File: rtl/my_sdram_pkg.sv
// rtl/my_sdram_pkg.sv - shared constants, FSM state types and helpers for the SDRAM AXI mux
package my_sdram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/my_sdram_axi_mux_if.sv
// rtl/my_sdram_axi_mux_if.sv - AXI4 bus bundle, N flattened slices (slice k = port k)
interface my_sdram_axi_mux_if #(
  parameter int N      = 1,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  localparam int SW = DATA_W / 8;

  logic [N-1:0]        awvalid, awready;
  logic [N*32-1:0]     awaddr;
  logic [N*ID_W-1:0]   awid;
  logic [N*8-1:0]      awlen;
  logic [N*2-1:0]      awburst;
  logic [N-1:0]        wvalid, wready, wlast;
  logic [N*DATA_W-1:0] wdata;
  logic [N*SW-1:0]     wstrb;
  logic [N-1:0]        bvalid, bready;
  logic [N*2-1:0]      bresp;
  logic [N*ID_W-1:0]   bid;
  logic [N-1:0]        arvalid, arready;
  logic [N*32-1:0]     araddr;
  logic [N*ID_W-1:0]   arid;
  logic [N*8-1:0]      arlen;
  logic [N*2-1:0]      arburst;
  logic [N-1:0]        rvalid, rready, rlast;
  logic [N*DATA_W-1:0] rdata;
  logic [N*2-1:0]      rresp;
  logic [N*ID_W-1:0]   rid;

  modport master (
    output awvalid, awaddr, awid, awlen, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input bvalid, bresp, bid, output bready,
    output arvalid, araddr, arid, arlen, arburst, input arready,
    input rvalid, rdata, rresp, rid, rlast, output rready
  );

  modport slave (
    input awvalid, awaddr, awid, awlen, awburst, output awready,
    input wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bresp, bid, input bready,
    input arvalid, araddr, arid, arlen, arburst, output arready,
    output rvalid, rdata, rresp, rid, rlast, input rready
  );

endinterface

// File: rtl/my_sdram_rr_arb.sv
// rtl/my_sdram_rr_arb.sv - round-robin picker with registered grant index
module my_sdram_rr_arb
  import my_sdram_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  localparam int IW = clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 pick,
  output logic [IW-1:0]        gnt
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] winner;
  logic          any;
  int            idx;

  // First requester strictly after the pointer, wrapping modulo NUM_PORTS.
  always_comb begin
    winner = ptr;
    any    = 1'b0;
    idx    = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = (int'(ptr) + i) % NUM_PORTS;
      if (!any && req[idx]) begin
        winner = IW'(idx);
        any    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= IW'(NUM_PORTS - 1);
      gnt <= '0;
    end else if (pick && any) begin
      ptr <= winner;
      gnt <= winner;
    end
  end

endmodule

// File: rtl/my_sdram_axi_mux.sv
// rtl/my_sdram_axi_mux.sv - N-port AXI4 front end arbitrating onto one sdram_axi port
// Optional MY_SDRAM_ADDR_CHECK_EN: addresses >= ADDR_LIMIT are answered locally with DECERR.
module my_sdram_axi_mux
  import my_sdram_pkg::*;
#(
  parameter int          NUM_PORTS  = 4,
  parameter int          DATA_W     = 32,
  parameter int          ID_W       = 4,
  parameter logic [31:0] ADDR_LIMIT = 32'h0200_0000
) (
  input  logic             clk,
  input  logic             reset_n,
  my_sdram_axi_mux_if.slave  s,
  my_sdram_axi_mux_if.master m
);

  localparam int IW = clog2(NUM_PORTS);
  localparam int SW = DATA_W / 8;

  wr_state_t         wstate;
  rd_state_t         rstate;
  logic [IW-1:0]     wgnt, rgnt;
  int                wi, ri;
  logic              wr_err, rd_err, aw_bad, ar_bad;
  logic              aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last;
  logic [ID_W-1:0]   err_bid, err_rid;
  logic              err_rlast;

  assign wi = int'(wgnt);
  assign ri = int'(rgnt);

`ifdef MY_SDRAM_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
  logic [ID_W-1:0] bid_q, rid_q;
  logic [7:0]      beats_left;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bid_q      <= '0;
      rid_q      <= '0;
      beats_left <= '0;
    end else begin
      if (wstate == W_ADDR && s.awvalid[wi] && aw_bad)
        bid_q <= s.awid[wi*ID_W +: ID_W];
      if (rstate == R_ADDR && s.arvalid[ri] && ar_bad) begin
        rid_q      <= s.arid[ri*ID_W +: ID_W];
        beats_left <= s.arlen[ri*8 +: 8];
      end else if (rstate == R_DATA && rd_err && s.rready[ri] && beats_left != 8'd0) begin
        beats_left <= beats_left - 8'd1;
      end
    end
  end

  assign err_bid   = bid_q;
  assign err_rid   = rid_q;
  assign err_rlast = (beats_left == 8'd0);
`else
  localparam bit CHECK_EN = 1'b0;
  assign err_bid   = '0;
  assign err_rid   = '0;
  assign err_rlast = 1'b1;
`endif

  assign aw_bad = CHECK_EN && (s.awaddr[wi*32 +: 32] >= ADDR_LIMIT);
  assign ar_bad = CHECK_EN && (s.araddr[ri*32 +: 32] >= ADDR_LIMIT);

  my_sdram_rr_arb #(.NUM_PORTS(NUM_PORTS)) u_aw_arb (
    .clk(clk), .reset_n(reset_n), .req(s.awvalid), .pick(wstate == W_IDLE), .gnt(wgnt)
  );

  my_sdram_rr_arb #(.NUM_PORTS(NUM_PORTS)) u_ar_arb (
    .clk(clk), .reset_n(reset_n), .req(s.arvalid), .pick(rstate == R_IDLE), .gnt(rgnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wstate <= W_IDLE;
      wr_err <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: if (|s.awvalid) wstate <= W_ADDR;
        W_ADDR: if (s.awvalid[wi] && aw_ready) begin
          wstate <= W_DATA;
          wr_err <= aw_bad;
        end
        W_DATA: if (s.wvalid[wi] && w_ready && s.wlast[wi]) wstate <= W_RESP;
        W_RESP: if (b_valid && s.bready[wi]) begin
          wstate <= W_IDLE;
          wr_err <= 1'b0;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rstate <= R_IDLE;
      rd_err <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: if (|s.arvalid) rstate <= R_ADDR;
        R_ADDR: if (s.arvalid[ri] && ar_ready) begin
          rstate <= R_DATA;
          rd_err <= ar_bad;
        end
        R_DATA: if (r_valid && s.rready[ri] && r_last) begin
          rstate <= R_IDLE;
          rd_err <= 1'b0;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // Write routing: only the granted slice ever sees a ready or valid.
  always_comb begin
    m.awvalid = 1'b0; m.awaddr = '0; m.awid = '0; m.awlen = '0; m.awburst = '0;
    m.wvalid  = 1'b0; m.wdata  = '0; m.wstrb = '0; m.wlast = 1'b0; m.bready = 1'b0;
    s.awready = '0; s.wready = '0; s.bvalid = '0; s.bresp = '0; s.bid = '0;
    aw_ready  = 1'b0; w_ready = 1'b0; b_valid = 1'b0;
    case (wstate)
      W_ADDR: begin
        aw_ready      = aw_bad ? 1'b1 : m.awready;
        m.awvalid     = s.awvalid[wi] & ~aw_bad;
        m.awaddr      = s.awaddr[wi*32 +: 32];
        m.awid        = s.awid[wi*ID_W +: ID_W];
        m.awlen       = s.awlen[wi*8 +: 8];
        m.awburst     = s.awburst[wi*2 +: 2];
        s.awready[wi] = aw_ready;
      end
      W_DATA: begin
        w_ready      = wr_err ? 1'b1 : m.wready;
        m.wvalid     = s.wvalid[wi] & ~wr_err;
        m.wdata      = s.wdata[wi*DATA_W +: DATA_W];
        m.wstrb      = s.wstrb[wi*SW +: SW];
        m.wlast      = s.wlast[wi];
        s.wready[wi] = w_ready;
      end
      W_RESP: begin
        b_valid                 = wr_err | m.bvalid;
        m.bready                = s.bready[wi] & ~wr_err;
        s.bvalid[wi]            = b_valid;
        s.bresp[wi*2 +: 2]      = wr_err ? RESP_DECERR : m.bresp;
        s.bid[wi*ID_W +: ID_W]  = wr_err ? err_bid : m.bid;
      end
      default: ;
    endcase
  end

  always_comb begin
    m.arvalid = 1'b0; m.araddr = '0; m.arid = '0; m.arlen = '0; m.arburst = '0; m.rready = 1'b0;
    s.arready = '0; s.rvalid = '0; s.rdata = '0; s.rresp = '0; s.rid = '0; s.rlast = '0;
    ar_ready  = 1'b0; r_valid = 1'b0; r_last = 1'b0;
    case (rstate)
      R_ADDR: begin
        ar_ready      = ar_bad ? 1'b1 : m.arready;
        m.arvalid     = s.arvalid[ri] & ~ar_bad;
        m.araddr      = s.araddr[ri*32 +: 32];
        m.arid        = s.arid[ri*ID_W +: ID_W];
        m.arlen       = s.arlen[ri*8 +: 8];
        m.arburst     = s.arburst[ri*2 +: 2];
        s.arready[ri] = ar_ready;
      end
      R_DATA: begin
        r_valid                     = rd_err | m.rvalid;
        r_last                      = rd_err ? err_rlast : m.rlast;
        m.rready                    = s.rready[ri] & ~rd_err;
        s.rvalid[ri]                = r_valid;
        s.rlast[ri]                 = r_last;
        s.rdata[ri*DATA_W +: DATA_W] = rd_err ? '0 : m.rdata;
        s.rresp[ri*2 +: 2]          = rd_err ? RESP_DECERR : m.rresp;
        s.rid[ri*ID_W +: ID_W]      = rd_err ? err_rid : m.rid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_my_sdram_axi_mux.sv
// tb/tb_my_sdram_axi_mux.sv - scoreboard bench for my_sdram_axi_mux with a stand-in sdram_axi slave
module tb_my_sdram_axi_mux;
  import my_sdram_pkg::*;

  localparam int          NP    = 4;
  localparam int          DW    = 32;
  localparam int          IDW   = 4;
  localparam logic [31:0] LIMIT = 32'h0200_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  my_sdram_axi_mux_if #(.N(NP), .DATA_W(DW), .ID_W(IDW)) s_if ();
  my_sdram_axi_mux_if #(.N(1),  .DATA_W(DW), .ID_W(IDW)) m_if ();

  my_sdram_axi_mux #(.NUM_PORTS(NP), .DATA_W(DW), .ID_W(IDW), .ADDR_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n), .s(s_if), .m(m_if)
  );

  typedef struct packed {logic [1:0] port; logic [31:0] data; logic [1:0] resp; logic [3:0] id; logic last;} rexp_t;
  typedef struct packed {logic [1:0] port; logic [3:0] id; logic [1:0] resp;} bexp_t;
  typedef struct packed {logic [31:0] data; logic [3:0] strb; logic last;} wexp_t;
  typedef struct packed {logic [31:0] addr; logic [3:0] id; logic [7:0] len;} aexp_t;

  rexp_t exp_r[$];
  bexp_t exp_b[$];
  wexp_t exp_w[$];
  aexp_t exp_ar[$];
  aexp_t exp_aw[$];

  int tests = 0;
  int fails = 0;
  int route_err = 0;
  int bad_other = 0;
  bit watch_w = 0;
  bit m_fwd_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got no event, required one within the cycle budget", name);
  endtask

  function automatic logic [31:0] wpat(input int p, input int b);
    return 32'hA000_0000 | (32'(p) << 16) | 32'(b);
  endfunction

  function automatic logic [31:0] rpat(input logic [31:0] a, input int b);
    return 32'h5A5A_0000 ^ (a + 32'(4 * b));
  endfunction

  task automatic exp_read(input int p, input logic [31:0] a, input logic [3:0] id, input int len);
    exp_ar.push_back('{addr: a, id: id, len: 8'(len)});
    for (int b = 0; b <= len; b++)
      exp_r.push_back('{port: 2'(p), data: rpat(a, b), resp: RESP_OKAY, id: id, last: (b == len)});
  endtask

  task automatic exp_write(input int p, input logic [31:0] a, input logic [3:0] id, input int len);
    exp_aw.push_back('{addr: a, id: id, len: 8'(len)});
    for (int b = 0; b <= len; b++)
      exp_w.push_back('{data: wpat(p, b), strb: 4'hF, last: (b == len)});
    exp_b.push_back('{port: 2'(p), id: id, resp: RESP_OKAY});
  endtask

  // Waits at negedges for a per-port ready/valid; sel: 0 awready, 1 wready, 2 bvalid, 3 arready.
  task automatic wait_hi(input string name, input int sel, input int p);
    int cyc;
    bit hit;
    cyc = 0;
    hit = 0;
    while (!hit && cyc < 300) begin
      @(negedge clk);
      cyc++;
      case (sel)
        0: hit = s_if.awready[p];
        1: hit = s_if.wready[p];
        2: hit = s_if.bvalid[p];
        default: hit = s_if.arready[p];
      endcase
    end
    if (!hit) fail_now(name);
  endtask

  task automatic up_write(input int p, input logic [31:0] a, input logic [3:0] id, input int len);
    s_if.awaddr[p*32 +: 32] = a;
    s_if.awid[p*4 +: 4]     = id;
    s_if.awlen[p*8 +: 8]    = 8'(len);
    s_if.awburst[p*2 +: 2]  = 2'b01;
    s_if.awvalid[p]         = 1'b1;
    wait_hi("aw_handshake", 0, p);
    @(posedge clk); #1;
    s_if.awvalid[p] = 1'b0;
    for (int b = 0; b <= len; b++) begin
      s_if.wdata[p*32 +: 32] = wpat(p, b);
      s_if.wstrb[p*4 +: 4]   = 4'hF;
      s_if.wlast[p]          = (b == len);
      s_if.wvalid[p]         = 1'b1;
      wait_hi("w_handshake", 1, p);
      @(posedge clk); #1;
    end
    s_if.wvalid[p] = 1'b0;
    s_if.wlast[p]  = 1'b0;
    s_if.bready[p] = 1'b1;
    wait_hi("b_handshake", 2, p);
    @(posedge clk); #1;
    s_if.bready[p] = 1'b0;
  endtask

  task automatic up_read(input int p, input logic [31:0] a, input logic [3:0] id, input int len, input int stall_after);
    int n;
    int cyc;
    bit done;
    n = 0;
    cyc = 0;
    done = 0;
    s_if.araddr[p*32 +: 32] = a;
    s_if.arid[p*4 +: 4]     = id;
    s_if.arlen[p*8 +: 8]    = 8'(len);
    s_if.arburst[p*2 +: 2]  = 2'b01;
    s_if.arvalid[p]         = 1'b1;
    s_if.rready[p]          = 1'b1;
    wait_hi("ar_handshake", 3, p);
    @(posedge clk); #1;
    s_if.arvalid[p] = 1'b0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (s_if.rvalid[p] && s_if.rready[p]) begin
        n++;
        if (s_if.rlast[p]) done = 1;
        else if (n == stall_after) begin
          @(posedge clk); #1;
          s_if.rready[p] = 1'b0;
          for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_m_rready", m_if.rready, 1'b0);
            check("stall_rvalid", s_if.rvalid[p], 1'b1);
            check("stall_rdata", s_if.rdata[p*32 +: 32], exp_r.size() != 0 ? exp_r[0].data : 32'hx);
          end
          @(posedge clk); #1;
          s_if.rready[p] = 1'b1;
        end
      end
    end
    if (!done) fail_now("r_burst_end");
    @(posedge clk); #1;
    s_if.rready[p] = 1'b0;
  endtask

  // Stand-in sdram_axi write side.
  initial begin : wr_slave
    logic [3:0] id;
    bit         done;
    aexp_t      e;
    wexp_t      w;
    m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.bvalid = 1'b0; m_if.bresp = '0; m_if.bid = '0;
    @(posedge reset_n);
    forever begin
      m_if.awready = 1'b1;
      do @(negedge clk); while (m_if.awvalid !== 1'b1);
      id = m_if.awid;
      if (exp_aw.size() == 0) fail_now("m_aw_unexpected");
      else begin
        e = exp_aw.pop_front();
        check("m_aw", {m_if.awaddr, m_if.awid, m_if.awlen}, e);
      end
      @(posedge clk); #1;
      m_if.awready = 1'b0;
      m_if.wready  = 1'b1;
      done = 0;
      while (!done) begin
        @(negedge clk);
        if (m_if.wvalid === 1'b1) begin
          if (exp_w.size() == 0) fail_now("m_w_unexpected");
          else begin
            w = exp_w.pop_front();
            check("m_w_beat", {m_if.wdata, m_if.wstrb, m_if.wlast}, w);
          end
          done = m_if.wlast;
        end
      end
      @(posedge clk); #1;
      m_if.wready = 1'b0;
      m_if.bvalid = 1'b1;
      m_if.bid    = id;
      m_if.bresp  = RESP_OKAY;
      do @(negedge clk); while (m_if.bready !== 1'b1);
      @(posedge clk); #1;
      m_if.bvalid = 1'b0;
    end
  end

  // Stand-in sdram_axi read side.
  initial begin : rd_slave
    logic [31:0] a;
    logic [3:0]  id;
    int          len;
    aexp_t       e;
    m_if.arready = 1'b0; m_if.rvalid = 1'b0; m_if.rdata = '0; m_if.rresp = '0; m_if.rid = '0; m_if.rlast = 1'b0;
    @(posedge reset_n);
    forever begin
      m_if.arready = 1'b1;
      do @(negedge clk); while (m_if.arvalid !== 1'b1);
      a   = m_if.araddr;
      id  = m_if.arid;
      len = int'(m_if.arlen);
      if (exp_ar.size() == 0) fail_now("m_ar_unexpected");
      else begin
        e = exp_ar.pop_front();
        check("m_ar_order", {m_if.araddr, m_if.arid, m_if.arlen}, e);
      end
      // Earlier reads must already be fully drained upstream.
      check("rd_serial", exp_r.size() != 0 ? {exp_r[0].id, exp_r[0].data} : 36'hx, {id, rpat(a, 0)});
      @(posedge clk); #1;
      m_if.arready = 1'b0;
      for (int b = 0; b <= len; b++) begin
        m_if.rvalid = 1'b1;
        m_if.rdata  = rpat(a, b);
        m_if.rid    = id;
        m_if.rresp  = RESP_OKAY;
        m_if.rlast  = (b == len);
        do @(negedge clk); while (m_if.rready !== 1'b1);
        @(posedge clk); #1;
      end
      m_if.rvalid = 1'b0;
      m_if.rlast  = 1'b0;
      m_if.rdata  = '0;
    end
  end

  // Upstream monitor: pops the scoreboard on every completed R/B handshake.
  always @(negedge clk) begin
    rexp_t ra, re;
    bexp_t ba, be;
    if (reset_n) begin
      if ($countones(s_if.rvalid) > 1 || $countones(s_if.bvalid) > 1) route_err++;
      if (watch_w && (((s_if.awready | s_if.wready | s_if.bvalid | s_if.arready | s_if.rvalid) & 4'b1101) != 4'b0))
        bad_other++;
      if (m_if.arvalid === 1'b1 || m_if.awvalid === 1'b1 || m_if.wvalid === 1'b1) m_fwd_seen = 1;
      for (int k = 0; k < NP; k++) begin
        if (s_if.rvalid[k] && s_if.rready[k]) begin
          ra = '{port: 2'(k), data: s_if.rdata[k*32 +: 32], resp: s_if.rresp[k*2 +: 2],
                 id: s_if.rid[k*4 +: 4], last: s_if.rlast[k]};
          if (exp_r.size() == 0) fail_now("r_unexpected");
          else begin
            re = exp_r.pop_front();
            check("r_beat", ra, re);
          end
        end
        if (s_if.bvalid[k] && s_if.bready[k]) begin
          ba = '{port: 2'(k), id: s_if.bid[k*4 +: 4], resp: s_if.bresp[k*2 +: 2]};
          if (exp_b.size() == 0) fail_now("b_unexpected");
          else begin
            be = exp_b.pop_front();
            check("b_resp", ba, be);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no end of test, required finish within 400us");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  task automatic check_all_idle(input string name);
    check({name, "_ctl"}, {s_if.awready, s_if.wready, s_if.bvalid, s_if.arready, s_if.rvalid,
                           m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready}, 64'd0);
    check({name, "_payload"}, {m_if.awaddr, m_if.wdata}, 64'd0);
    check({name, "_rdata"}, {s_if.rdata[63:0]}, 64'd0);
  endtask

  initial begin : main
    s_if.awvalid = '0; s_if.awaddr = '0; s_if.awid = '0; s_if.awlen = '0; s_if.awburst = '0;
    s_if.wvalid = '0; s_if.wdata = '0; s_if.wstrb = '0; s_if.wlast = '0; s_if.bready = '0;
    s_if.arvalid = '0; s_if.araddr = '0; s_if.arid = '0; s_if.arlen = '0; s_if.arburst = '0;
    s_if.rready = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_idle("reset_state");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Port 1 write, other ports must stay silent.
    exp_write(1, 32'h100, 4'h5, 3);
    watch_w = 1;
    up_write(1, 32'h100, 4'h5, 3);
    watch_w = 0;
    check("t1_nongranted_activity", bad_other, 0);

    // Ports 0 and 2 contend twice: order 0, 2, 0, 2.
    for (int r = 0; r < 2; r++) begin
      exp_read(0, 32'h200 + 32'(r * 16'h40), 4'h1, 1);
      exp_read(2, 32'h280 + 32'(r * 16'h40), 4'h2, 2);
      fork
        up_read(0, 32'h200 + 32'(r * 16'h40), 4'h1, 1, 0);
        up_read(2, 32'h280 + 32'(r * 16'h40), 4'h2, 2, 0);
      join
    end

    // Concurrent write on port 0 and read on port 3.
    exp_write(0, 32'h300, 4'h7, 2);
    exp_read(3, 32'h400, 4'h9, 3);
    fork
      up_write(0, 32'h300, 4'h7, 2);
      up_read(3, 32'h400, 4'h9, 3, 0);
    join

`ifdef MY_SDRAM_ADDR_CHECK_EN
    m_fwd_seen = 0;
    for (int b = 0; b <= 3; b++)
      exp_r.push_back('{port: 2'd1, data: 32'd0, resp: RESP_DECERR, id: 4'hA, last: (b == 3)});
    up_read(1, LIMIT, 4'hA, 3, 0);
    exp_b.push_back('{port: 2'd0, id: 4'h6, resp: RESP_DECERR});
    up_write(0, LIMIT + 32'h40, 4'h6, 1);
    check("decerr_not_forwarded", m_fwd_seen, 1'b0);
`endif

    // Port 2 read with a 5-cycle rready stall after beat 2.
    exp_read(2, 32'h500, 4'hC, 4);
    up_read(2, 32'h500, 4'hC, 4, 2);

    // Reset during a write data beat on port 1.
    exp_aw.push_back('{addr: 32'h600, id: 4'h3, len: 8'd3});
    exp_w.push_back('{data: wpat(1, 0), strb: 4'hF, last: 1'b0});
    s_if.awaddr[63:32] = 32'h600; s_if.awid[7:4] = 4'h3; s_if.awlen[15:8] = 8'd3; s_if.awburst[3:2] = 2'b01;
    s_if.awvalid[1] = 1'b1;
    wait_hi("rst_aw_handshake", 0, 1);
    @(posedge clk); #1;
    s_if.awvalid[1] = 1'b0;
    s_if.wdata[63:32] = wpat(1, 0); s_if.wstrb[7:4] = 4'hF; s_if.wlast[1] = 1'b0; s_if.wvalid[1] = 1'b1;
    wait_hi("rst_w_handshake", 1, 1);
    @(posedge clk); #1;
    s_if.wdata[63:32] = wpat(1, 1);
    #1;
    check("pre_reset_m_wvalid", m_if.wvalid, 1'b1);
    reset_n = 1'b0;
    #1;
    check_all_idle("mid_burst_reset");
    s_if.wvalid = '0; s_if.wdata = '0; s_if.wstrb = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // After reset port 0 must beat port 3.
    exp_read(0, 32'h700, 4'h1, 0);
    exp_read(3, 32'h780, 4'h2, 0);
    fork
      up_read(0, 32'h700, 4'h1, 0, 0);
      up_read(3, 32'h780, 4'h2, 0, 0);
    join

    repeat (3) @(posedge clk);
    check("route_violations", route_err, 0);
    check("left_r", exp_r.size(), 0);
    check("left_b", exp_b.size(), 0);
    check("left_w", exp_w.size(), 0);
    check("left_ar", exp_ar.size(), 0);
    check("left_aw", exp_aw.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
